// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch controller and its
// next-PC helper.
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_RESP = 2'd1,
    ST_OUT  = 2'd2,
    ST_WB   = 2'd3
  } ifu_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int          XLEN_DEFAULT     = 32;
  localparam int          ILEN_DEFAULT     = 32;

  // Bytes between consecutive sequential instructions.
  function automatic int fetch_step(input int ilen);
    return ilen / 8;
  endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// Next-PC datapath: picks base and addend from the EXU controls, adds them,
// and clears bit 0 for register-relative jumps.
module ifu_next_pc
  import ifu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int ILEN = ILEN_DEFAULT
) (
  input  logic [XLEN-1:0] pc,
  input  logic            pca_sel,
  input  logic            pcb_sel,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] next_pc
);

  localparam logic [XLEN-1:0] STEP = XLEN'(fetch_step(ILEN));

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] addend;
  logic [XLEN-1:0] sum;

  assign base   = pcb_sel ? rs1 : pc;
  assign addend = pca_sel ? imm : STEP;
  // Wraps modulo 2^XLEN; no carry out is kept.
  assign sum    = base + addend;

  always_comb begin
    next_pc = sum;
    if (pcb_sel) begin
      next_pc[0] = 1'b0;
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: holds the PC, fetches over a variable-latency
// request/response port and presents each instruction (or fault) to the IDU.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int          XLEN        = XLEN_DEFAULT,
  parameter int          ILEN        = ILEN_DEFAULT,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          ALIGN_CHECK = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wbu_finish,
  input  logic            pca_sel,
  input  logic            pcb_sel,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [ILEN-1:0] mem_resp_data,
  input  logic            mem_resp_err,
  output logic            ifu_valid,
  input  logic            idu_ready,
  output logic [XLEN-1:0] ifu_pc,
  output logic [ILEN-1:0] ifu_inst,
  output logic            ifu_fault,
  output ifu_state_t      dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high. The sender holds valid and its payload stable until that cycle;
  // ready may change freely and has no effect while valid is low.

  localparam int              STEP_BYTES = fetch_step(ILEN);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP_BYTES - 1);
  localparam logic [XLEN-1:0] PC_INIT    = XLEN'(RESET_PC);

  ifu_state_t      state;
  ifu_state_t      state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            pc_advance;

  assign misaligned   = (ALIGN_CHECK != 0) && ((pc & ALIGN_MASK) != '0);
  assign pc_advance   = (state == ST_WB) && wbu_finish;
  assign mem_req_addr = pc;
  assign ifu_pc       = pc;
  assign ifu_valid    = (state == ST_OUT);
  assign dbg_state    = state;

  ifu_next_pc #(
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_next_pc (
    .pc      (pc),
    .pca_sel (pca_sel),
    .pcb_sel (pcb_sel),
    .rs1     (rs1),
    .imm     (imm),
    .next_pc (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_REQ;
    end else begin
      state <= state_next;
    end
  end

  // Request is masked during reset so a ready seen on the reset edge is lost.
  always_comb begin
    state_next    = state;
    mem_req_valid = 1'b0;
    case (state)
      ST_REQ: begin
        if (misaligned) begin
          state_next = ST_OUT;
        end else begin
          mem_req_valid = !rst;
          if (mem_req_ready) begin
            state_next = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (mem_resp_valid) begin
          state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        if (idu_ready) begin
          state_next = ST_WB;
        end
      end
      ST_WB: begin
        if (wbu_finish) begin
          state_next = ST_REQ;
        end
      end
      default: begin
        state_next = ST_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= PC_INIT;
    end else if (pc_advance) begin
      pc <= next_pc;
    end
  end

  // Slot payload; a faulting slot always carries a zero instruction word.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifu_inst  <= '0;
      ifu_fault <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (misaligned) begin
            ifu_inst  <= '0;
            ifu_fault <= 1'b1;
          end
        end
        ST_RESP: begin
          if (mem_resp_valid) begin
            ifu_inst  <= mem_resp_err ? '0 : mem_resp_data;
            ifu_fault <= mem_resp_err;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: walks fetch, branch, JALR, wrap, fault,
// backpressure and reset scenarios with hand-computed expectations.
module tb_ifu_fetch_ctrl;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wbu_finish = 1'b0;
  logic        pca_sel = 1'b0;
  logic        pcb_sel = 1'b0;
  logic [31:0] rs1 = '0;
  logic [31:0] imm = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        mem_resp_err = 1'b0;
  logic        ifu_valid;
  logic        idu_ready = 1'b0;
  logic [31:0] ifu_pc;
  logic [31:0] ifu_inst;
  logic        ifu_fault;
  ifu_state_t  dbg_state;

  int total = 0;
  int bad   = 0;
  int vld_cnt = 0;

  ifu_fetch_ctrl #(
    .XLEN        (32),
    .ILEN        (32),
    .RESET_PC    (32'h8000_0000),
    .ALIGN_CHECK (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wbu_finish     (wbu_finish),
    .pca_sel        (pca_sel),
    .pcb_sel        (pcb_sel),
    .rs1            (rs1),
    .imm            (imm),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err),
    .ifu_valid      (ifu_valid),
    .idu_ready      (idu_ready),
    .ifu_pc         (ifu_pc),
    .ifu_inst       (ifu_inst),
    .ifu_fault      (ifu_fault),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ifu_valid) vld_cnt++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expects state REQ at addr; holds ready low for ready_delay cycles first.
  task automatic req_accept(input string tag, input logic [31:0] addr, input int ready_delay);
    for (int i = 0; i < ready_delay; i++) begin
      check({tag, "_stall_valid"}, 64'(mem_req_valid), 64'd1);
      check({tag, "_stall_addr"}, 64'(mem_req_addr), 64'(addr));
      tick();
    end
    check({tag, "_req_valid"}, 64'(mem_req_valid), 64'd1);
    check({tag, "_req_addr"}, 64'(mem_req_addr), 64'(addr));
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check({tag, "_in_resp"}, 64'(dbg_state), 64'(ST_RESP));
  endtask

  task automatic resp_give(input string tag, input int idle, input logic [31:0] data, input logic err);
    for (int i = 0; i < idle; i++) begin
      tick();
      check({tag, "_wait_novalid"}, 64'(ifu_valid), 64'd0);
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    mem_resp_err   = err;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_err   = 1'b0;
  endtask

  // Checks the presented slot, holds it for hold cycles, then hands it off.
  task automatic out_take(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic fault, input int hold);
    for (int i = 0; i <= hold; i++) begin
      check({tag, "_valid"}, 64'(ifu_valid), 64'd1);
      check({tag, "_pc"}, 64'(ifu_pc), 64'(pc));
      check({tag, "_inst"}, 64'(ifu_inst), 64'(inst));
      check({tag, "_fault"}, 64'(ifu_fault), 64'(fault));
      if (i < hold) tick();
    end
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    check({tag, "_valid_clr"}, 64'(ifu_valid), 64'd0);
    check({tag, "_in_wb"}, 64'(dbg_state), 64'(ST_WB));
  endtask

  task automatic finish(input string tag, input logic a, input logic b,
                        input logic [31:0] r, input logic [31:0] i, input logic [31:0] exp_pc);
    wbu_finish = 1'b1;
    pca_sel = a;
    pcb_sel = b;
    rs1 = r;
    imm = i;
    tick();
    wbu_finish = 1'b0;
    pca_sel = 1'b0;
    pcb_sel = 1'b0;
    rs1 = '0;
    imm = '0;
    check({tag, "_next_pc"}, 64'(mem_req_addr), 64'(exp_pc));
    check({tag, "_in_req"}, 64'(dbg_state), 64'(ST_REQ));
  endtask

  initial begin
    // Reset: a ready during reset must not be taken.
    rst = 1'b1;
    mem_req_ready = 1'b1;
    tick();
    tick();
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_ifu_valid", 64'(ifu_valid), 64'd0);
    check("rst_fault", 64'(ifu_fault), 64'd0);
    check("rst_inst", 64'(ifu_inst), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_REQ));
    check("rst_pc", 64'(ifu_pc), 64'h8000_0000);
    mem_req_ready = 1'b0;
    rst = 1'b0;
    #1;

    // First fetch: accept at once, response two cycles later, IDU stalls 3.
    req_accept("f0", 32'h8000_0000, 0);
    resp_give("f0", 1, 32'h0000_0013, 1'b0);
    out_take("f0", 32'h8000_0000, 32'h0000_0013, 1'b0, 3);
    finish("seq", 1'b0, 1'b0, 32'h0, 32'h0, 32'h8000_0004);

    req_accept("f1", 32'h8000_0004, 0);
    resp_give("f1", 0, 32'h0010_0093, 1'b0);
    out_take("f1", 32'h8000_0004, 32'h0010_0093, 1'b0, 0);
    finish("br_neg", 1'b1, 1'b0, 32'h0, 32'hFFFF_FFF8, 32'h7FFF_FFFC);

    req_accept("f2", 32'h7FFF_FFFC, 0);
    resp_give("f2", 0, 32'hDEAD_BEEF, 1'b0);
    out_take("f2", 32'h7FFF_FFFC, 32'hDEAD_BEEF, 1'b0, 0);
    finish("jalr", 1'b1, 1'b1, 32'h8000_1001, 32'h4, 32'h8000_1004);

    // Access fault from memory: slot still goes OUT then WB.
    req_accept("f3", 32'h8000_1004, 0);
    resp_give("f3", 0, 32'h0, 1'b1);
    out_take("f3", 32'h8000_1004, 32'h0, 1'b1, 0);
    finish("to_top", 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h4, 32'hFFFF_FFFC);

    req_accept("f4", 32'hFFFF_FFFC, 0);
    resp_give("f4", 0, 32'h1234_5678, 1'b0);
    out_take("f4", 32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 0);
    finish("wrap", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0000);

    req_accept("f5", 32'h0000_0000, 0);
    resp_give("f5", 0, 32'h0000_0073, 1'b0);
    out_take("f5", 32'h0000_0000, 32'h0000_0073, 1'b0, 0);
    finish("to_mis", 1'b1, 1'b1, 32'h8000_0000, 32'h2, 32'h8000_0002);

    // Misaligned PC: no request, fault slot on the next cycle.
    check("mis_no_req", 64'(mem_req_valid), 64'd0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    out_take("mis", 32'h8000_0002, 32'h0, 1'b1, 0);
    finish("redir", 1'b0, 1'b1, 32'h8000_0000, 32'h0, 32'h8000_0004);

    // Backpressure: ready low 5, response after 7 idle cycles with a stray finish.
    vld_cnt = 0;
    req_accept("bp", 32'h8000_0004, 5);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        wbu_finish = 1'b1;
        pca_sel = 1'b1;
        imm = 32'h100;
      end
      tick();
      wbu_finish = 1'b0;
      pca_sel = 1'b0;
      imm = '0;
      check("bp_wait_novalid", 64'(ifu_valid), 64'd0);
      check("bp_pc_hold", 64'(ifu_pc), 64'h8000_0004);
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hCAFE_F00D;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    out_take("bp", 32'h8000_0004, 32'hCAFE_F00D, 1'b0, 0);
    tick();
    tick();
    check("bp_one_pulse", 64'(vld_cnt), 64'd1);
    finish("bp_seq", 1'b0, 1'b0, 32'h0, 32'h0, 32'h8000_0008);

    // Reset while waiting for a response; a late response is then ignored.
    req_accept("rr", 32'h8000_0008, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_state", 64'(dbg_state), 64'(ST_REQ));
    check("rr_pc", 64'(ifu_pc), 64'h8000_0000);
    check("rr_valid", 64'(ifu_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hBAD0_BAD0;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    check("rr_late_state", 64'(dbg_state), 64'(ST_REQ));
    check("rr_late_valid", 64'(ifu_valid), 64'd0);
    check("rr_late_inst", 64'(ifu_inst), 64'd0);
    check("rr_req_again", 64'(mem_req_valid), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
